// File: rtl/pkt_buffer_rd_arbiter.sv
// pkt_buffer_rd_arbiter: shares the packet-buffer read port between NUM_REQ burst
// requesters, issues one read per cycle, tracks in-flight reads in a tag pipeline
// matched to RD_LATENCY, and steers returned flits to their owner.
// Optional feature macro: PKTBUF_ARB_STRICT_PRIO_EN (lowest-index eligible requester
// always wins; round-robin when undefined).
module pkt_buffer_rd_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int RD_LATENCY    = 12,
  parameter int PKTBUF_AWIDTH = 10,
  parameter int FLIT_WIDTH    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][PKTBUF_AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][4:0]               req_flits,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    rsp_almost_full,
  output logic [PKTBUF_AWIDTH-1:0]              pkt_buffer_address,
  output logic                                  pkt_buffer_read,
  input  logic                                  pkt_buffer_readvalid,
  input  logic [FLIT_WIDTH-1:0]                 pkt_buffer_readdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [FLIT_WIDTH-1:0]                 rsp_data,
  output logic                                  rsp_last,
  output logic                                  err
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int DRAIN_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] owner;
    logic             last;
  } tag_t;

  state_t                   state_q, state_d;
  logic [PKTBUF_AWIDTH-1:0] addr_q, addr_d;
  logic [4:0]               remain_q, remain_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic                     err_q, err_d;
  logic [DRAIN_W-1:0]       drain_q, drain_d;
  tag_t                     tags_q [RD_LATENCY];
  tag_t                     tags_d [RD_LATENCY];
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [FLIT_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                     rsp_last_q, rsp_last_d;

  logic [NUM_REQ-1:0]       eligible;
  logic                     grant_found;
  logic [IDX_W-1:0]         grant_idx;
  logic                     arb_now;
  logic                     take_grant;
  logic                     tag_mismatch;
  tag_t                     head;

  assign eligible = req_valid & ~rsp_almost_full;

`ifdef PKTBUF_ARB_STRICT_PRIO_EN
  // Fixed priority: scanning downward leaves the lowest eligible index as the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W:0]   cand;

  // Round-robin: first eligible requester starting one past the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!grant_found && eligible[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Remember the winner so the next search starts just after it.
  always_comb begin
    last_grant_d = take_grant ? grant_idx : last_grant_q;
  end

  // Round-robin pointer register; resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= IDX_W'(NUM_REQ - 1);
    else     last_grant_q <= last_grant_d;
  end
`endif

  // Burst FSM: grant in IDLE or on the final read of a burst, issue reads, push tags.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    owner_d         = owner_q;
    err_d           = err_q;
    req_ready       = '0;
    pkt_buffer_read = 1'b0;
    arb_now         = 1'b0;
    take_grant      = 1'b0;
    tags_d[0]       = '0;
    for (int i = 1; i < RD_LATENCY; i++) tags_d[i] = tags_q[i-1];
    case (state_q)
      IDLE: arb_now = 1'b1;
      BURST: begin
        pkt_buffer_read  = 1'b1;
        addr_d           = addr_q + PKTBUF_AWIDTH'(1);
        remain_d         = remain_q - 5'd1;
        tags_d[0].valid  = 1'b1;
        tags_d[0].owner  = owner_q;
        tags_d[0].last   = (remain_q == 5'd1);
        if (remain_q == 5'd1) begin
          arb_now = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_now && grant_found && !rst) begin
      take_grant           = 1'b1;
      req_ready[grant_idx] = 1'b1;
      if (req_flits[grant_idx] == 5'd0) begin
        err_d = 1'b1;
      end else begin
        state_d  = BURST;
        addr_d   = req_addr[grant_idx];
        remain_d = req_flits[grant_idx];
        owner_d  = grant_idx;
      end
    end
    if (tag_mismatch) err_d = 1'b1;
  end

  // Return path: match readvalid against the head tag; after reset, stray returns drain silently.
  always_comb begin
    head         = tags_q[RD_LATENCY-1];
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_last_d   = 1'b0;
    tag_mismatch = 1'b0;
    drain_d      = (drain_q != '0) ? drain_q - DRAIN_W'(1) : drain_q;
    if (pkt_buffer_readvalid && head.valid) begin
      rsp_valid_d[head.owner] = 1'b1;
      rsp_data_d              = pkt_buffer_readdata;
      rsp_last_d              = head.last;
    end else if (pkt_buffer_readvalid) begin
      tag_mismatch = (drain_q == '0);
    end else if (head.valid) begin
      tag_mismatch = 1'b1;
    end
  end

  // State, tag pipeline and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      owner_q     <= '0;
      err_q       <= 1'b0;
      drain_q     <= DRAIN_W'(RD_LATENCY);
      tags_q      <= '{default: '0};
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      drain_q     <= drain_d;
      tags_q      <= tags_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign pkt_buffer_address = addr_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_last           = rsp_last_q;
  assign err                = err_q;

endmodule
